// File: rtl/serial_addsub_unit_pkg.sv
// Shared types, constants and helpers for the bit-serial add/subtract stage.
package serial_addsub_unit_pkg;

  localparam int unsigned DATA_W = 9;
  localparam int unsigned CNT_W  = 4;

  // FSM state encoding (kept as plain constants for legacy tools).
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef logic [DATA_W-1:0] word_t;

  // Result and flags as presented to the outside world.
  typedef struct packed {
    word_t result;
    logic  carry_out;
    logic  overflow;
    logic  zero;
  } status_t;

  // Full-adder carry.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Widen an 8-bit operand to the 9-bit datapath.
  function automatic word_t ext8(input logic [7:0] v, input logic sgn);
    return {sgn & v[7], v};
  endfunction

endpackage

// File: rtl/serial_addsub_unit_if.sv
// Request/response bundle between the ALU sequencer and the serial add/sub stage.
interface serial_addsub_unit_if;
  import serial_addsub_unit_pkg::*;

  logic        start;
  logic        op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  word_t       result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, overflow, zero
  );

endinterface

// File: rtl/exor_wordgate.sv
// Conditional word inverter: every bit of word_i XORed with control_signal_i.
module exor_wordgate #(
  parameter int unsigned Width = 9
) (
  input  logic [Width-1:0] word_i,
  input  logic             control_signal_i,
  output logic [Width-1:0] word_o
);

  assign word_o = word_i ^ {Width{control_signal_i}};

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial 9-bit adder/subtractor: one bit per clock, LSB first, start/done handshake.
module serial_addsub_unit
  import serial_addsub_unit_pkg::*;
#(
  parameter bit          SIGNED = 1'b1,
  parameter int unsigned WIDTH  = DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_addsub_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  status_t          out_q, out_d;

  logic [WIDTH-1:0] b_gated;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] acc_shift;

  // B is inverted for subtraction; the +1 comes from the initial carry.
  exor_wordgate #(
    .Width (WIDTH)
  ) u_wordgate (
    .word_i           (ext8(bus.b, SIGNED)),
    .control_signal_i (bus.op),
    .word_o           (b_gated)
  );

  // Full-adder slice and next-state sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    acc_d     = acc_q;
    out_d     = out_q;
    sum_bit   = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    carry_nxt = maj3(op_a_q[0], op_b_q[0], carry_q);
    acc_shift = {sum_bit, acc_q[WIDTH-1:1]};

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_a_d  = ext8(bus.a, SIGNED);
          op_b_d  = b_gated;
          carry_d = bus.op;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        carry_d = carry_nxt;
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        acc_d   = acc_shift;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          // Output register is loaded only here so it holds through the next SHIFT.
          out_d.result    = acc_shift;
          out_d.carry_out = carry_nxt;
          out_d.overflow  = SIGNED ? (acc_shift[WIDTH-1] ^ acc_shift[WIDTH-2]) : 1'b0;
          out_d.zero      = (acc_shift == '0);
          state_d         = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  // Status outputs decoded from state; data outputs from the held output register.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.result    = out_q.result;
    bus.carry_out = out_q.carry_out;
    bus.overflow  = out_q.overflow;
    bus.zero      = out_q.zero;
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench: stimulus pushes expected results, negedge monitors pop and compare.
module tb_serial_addsub_unit;
  import serial_addsub_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [8:0]  res;
    logic        co;
    logic        ov;
    logic        z;
    int unsigned cyc;
  } exp_t;

  exp_t q_s[$];
  exp_t q_u[$];
  exp_t e_s, e_u;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_unit_if bus_s ();
  serial_addsub_unit_if bus_u ();

  serial_addsub_unit #(.SIGNED(1'b1), .WIDTH(9)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  serial_addsub_unit #(.SIGNED(1'b0), .WIDTH(9)) u_dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_u)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the signed instance.
  always @(negedge clk) begin
    if (rst_n && bus_s.done === 1'b1) begin
      if (q_s.size() == 0) begin
        check("s_done_without_request", bus_s.done, 0);
      end else begin
        e_s = q_s.pop_front();
        check("s_result", bus_s.result, e_s.res);
        check("s_carry_out", bus_s.carry_out, e_s.co);
        check("s_overflow", bus_s.overflow, e_s.ov);
        check("s_zero", bus_s.zero, e_s.z);
        check("s_done_cycle", cyc, e_s.cyc);
      end
    end
  end

  // Monitor for the unsigned instance.
  always @(negedge clk) begin
    if (rst_n && bus_u.done === 1'b1) begin
      if (q_u.size() == 0) begin
        check("u_done_without_request", bus_u.done, 0);
      end else begin
        e_u = q_u.pop_front();
        check("u_result", bus_u.result, e_u.res);
        check("u_carry_out", bus_u.carry_out, e_u.co);
        check("u_overflow", bus_u.overflow, e_u.ov);
        check("u_zero", bus_u.zero, e_u.z);
        check("u_done_cycle", cyc, e_u.cyc);
      end
    end
  end

  // Issue one request while the DUT is idle; done is due 9 edges after the accept edge.
  task automatic issue(input bit uns, input logic op, input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] res, input logic co, input logic ov, input logic z,
                       input bit push);
    @(negedge clk);
    if (uns) begin
      bus_u.start = 1'b1; bus_u.op = op; bus_u.a = a; bus_u.b = b;
    end else begin
      bus_s.start = 1'b1; bus_s.op = op; bus_s.a = a; bus_s.b = b;
    end
    @(posedge clk);
    #1;
    if (push) begin
      if (uns) q_u.push_back('{res, co, ov, z, cyc + 9});
      else     q_s.push_back('{res, co, ov, z, cyc + 9});
    end
    @(negedge clk);
    if (uns) bus_u.start = 1'b0;
    else     bus_s.start = 1'b0;
  endtask

  // Bounded wait for all outstanding expectations to be consumed.
  task automatic drain(input string name);
    for (int i = 0; i < 60 && (q_s.size() != 0 || q_u.size() != 0); i++) @(negedge clk);
    check({name, "_drain_s"}, q_s.size(), 0);
    check({name, "_drain_u"}, q_u.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus_s.start = 1'b0; bus_s.op = OP_ADD; bus_s.a = '0; bus_s.b = '0;
    bus_u.start = 1'b0; bus_u.op = OP_ADD; bus_u.a = '0; bus_u.b = '0;

    // Reset state
    #1;
    check("rst_s_busy", bus_s.busy, 0);
    check("rst_s_done", bus_s.done, 0);
    check("rst_s_result", bus_s.result, 0);
    check("rst_s_carry", bus_s.carry_out, 0);
    check("rst_s_ovf", bus_s.overflow, 0);
    check("rst_s_zero", bus_s.zero, 0);
    check("rst_u_busy", bus_u.busy, 0);
    check("rst_u_result", bus_u.result, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 5 - 3
    issue(1'b0, OP_SUB, 8'h05, 8'h03, 9'h002, 1'b1, 1'b0, 1'b0, 1'b1);
    drain("sub_5_3");
    // 127 + 1 signed overflow
    issue(1'b0, OP_ADD, 8'h7F, 8'h01, 9'h080, 1'b0, 1'b1, 1'b0, 1'b1);
    drain("add_7f_1");
    // -128 - 1 signed overflow
    issue(1'b0, OP_SUB, 8'h80, 8'h01, 9'h17F, 1'b1, 1'b1, 1'b0, 1'b1);
    drain("sub_80_1");

    // Start during SHIFT is ignored; outputs hold previous values until done
    issue(1'b0, OP_ADD, 8'h10, 8'h20, 9'h030, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    bus_s.start = 1'b1; bus_s.op = OP_SUB; bus_s.a = 8'hFF; bus_s.b = 8'hFF;
    @(negedge clk);
    bus_s.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("ign_busy", bus_s.busy, 1);
      check("ign_hold_result", bus_s.result, 9'h17F);
      check("ign_hold_ovf", bus_s.overflow, 1);
      @(negedge clk);
    end
    check("ign_busy_at_done", bus_s.busy, 1);
    @(negedge clk);
    check("ign_idle_after_done", bus_s.busy, 0);
    drain("ignore");

    // 42 - 42 = 0
    issue(1'b0, OP_SUB, 8'h2A, 8'h2A, 9'h000, 1'b1, 1'b0, 1'b1, 1'b1);
    drain("sub_2a_2a");

    // Unsigned 255 + 1
    issue(1'b1, OP_ADD, 8'hFF, 8'h01, 9'h100, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("u_add_ff_1");

    // start held high: accepts at E0, E11, E22
    @(negedge clk);
    bus_s.start = 1'b1; bus_s.op = OP_ADD; bus_s.a = 8'h7F; bus_s.b = 8'h01;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      q_s.push_back('{9'h080, 1'b0, 1'b1, 1'b0, cyc + 9});
      if (k < 2) repeat (10) @(posedge clk);
    end
    @(negedge clk);
    bus_s.start = 1'b0;
    drain("held_start");

    // Asynchronous reset in the middle of SHIFT; no done may follow
    issue(1'b0, OP_SUB, 8'h33, 8'h11, 9'h022, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus_s.busy, 0);
    check("arst_done", bus_s.done, 0);
    check("arst_result", bus_s.result, 0);
    check("arst_carry", bus_s.carry_out, 0);
    check("arst_ovf", bus_s.overflow, 0);
    check("arst_zero", bus_s.zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("arst_idle_after", bus_s.busy, 0);

    // 1 + 1 after reset
    issue(1'b0, OP_ADD, 8'h01, 8'h01, 9'h002, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("add_1_1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
